// File: rtl/ok_snapshot_pager_if.sv
// Host-facing bundle of the snapshot pager: live channels in, wireIn control
// word in, paged wireOut data, status word and board LEDs out.
interface ok_snapshot_pager_if #(
  parameter int NUM_CH  = 16,
  parameter int NUM_OUT = 5
);
  logic [16*NUM_CH-1:0]  ch_data;
  logic [15:0]           ep_ctrl;
  logic [16*NUM_OUT-1:0] ep_out;
  logic [15:0]           ep_status;
  logic [7:0]            led;

  modport master (output ch_data, output ep_ctrl,
                  input  ep_out,  input  ep_status, input led);
  modport slave  (input  ch_data, input  ep_ctrl,
                  output ep_out,  output ep_status, output led);
endinterface

// File: rtl/ok_snapshot_pager.sv
// Snapshot-coherent paged status bridge: captures every channel on one edge,
// then loads one page of words into the wireOut bank under a req/ack handshake.
module ok_snapshot_pager #(
  parameter int NUM_CH  = 16,
  parameter int NUM_OUT = 5
) (
  input  logic               clock,
  input  logic               reset,
  ok_snapshot_pager_if.slave bus
);

  localparam int         NUM_PAGES   = (NUM_CH + NUM_OUT - 1) / NUM_OUT;
  localparam logic [4:0] NUM_PAGES_W = 5'(NUM_PAGES);
  localparam logic [3:0] LAST_WORD   = 4'(NUM_OUT - 1);
  localparam logic [8:0] NUM_OUT_W   = 9'(NUM_OUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_LOAD,
    S_ACK
  } state_t;

  state_t      state, next_state;
  logic [15:0] snap     [NUM_CH];
  logic [15:0] out_bank [NUM_OUT];
  logic [7:0]  seq;
  logic [3:0]  page_q;
  logic        page_err;
  logic [3:0]  word_idx;

  logic        req;
  logic        load_only;
  logic        page_ok;
  logic [8:0]  rd_idx;
  logic [15:0] load_word;
  logic        ack;
  logic        busy;
  logic [15:0] status_w;

  assign req       = bus.ep_ctrl[0];
  assign load_only = bus.ep_ctrl[1];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:    if (req) next_state = load_only ? S_LOAD : S_CAPTURE;
      S_CAPTURE: next_state = S_LOAD;
      S_LOAD:    if (word_idx == LAST_WORD) next_state = S_ACK;
      S_ACK:     if (!req) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Out-of-range pages and indices past the last channel both read as zero.
  always_comb begin
    rd_idx    = 9'(page_q) * NUM_OUT_W + 9'(word_idx);
    page_ok   = {1'b0, page_q} < NUM_PAGES_W;
    load_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (page_ok && rd_idx == 9'(k)) load_word = snap[k];
    end
  end

  // NOTE: the snapshot and output banks are register arrays, not RAM, and
  // must be cleared on reset because the host can re-page them in mode 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++)  snap[k]     <= '0;
      for (int j = 0; j < NUM_OUT; j++) out_bank[j] <= '0;
      seq      <= '0;
      page_q   <= '0;
      page_err <= 1'b0;
      word_idx <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          word_idx <= '0;
          if (req) begin
            page_q   <= bus.ep_ctrl[11:8];
            page_err <= 1'b0;
          end
        end
        S_CAPTURE: begin
          for (int k = 0; k < NUM_CH; k++) snap[k] <= bus.ch_data[16*k +: 16];
          seq <= seq + 8'd1;
        end
        S_LOAD: begin
          for (int j = 0; j < NUM_OUT; j++) begin
            if (word_idx == 4'(j)) out_bank[j] <= load_word;
          end
          word_idx <= word_idx + 4'd1;
          if (!page_ok) page_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Every output derives from registers only; no input reaches an output
  // combinationally.
  assign ack      = (state == S_ACK);
  assign busy     = (state == S_CAPTURE) || (state == S_LOAD);
  assign status_w = {seq, page_q, 1'b0, page_err, busy, ack};

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
    assign bus.ep_out[16*j +: 16] = out_bank[j];
  end

  assign bus.ep_status = status_w;
  assign bus.led       = ~status_w[7:0];

endmodule

// File: tb/tb_ok_snapshot_pager.sv
// Scoreboard bench for ok_snapshot_pager: the driver queues the expected page
// and status per transaction, the monitor checks them on each rising ack.
module tb_ok_snapshot_pager;

  localparam int NUM_CH  = 16;
  localparam int NUM_OUT = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  ok_snapshot_pager_if #(.NUM_CH(NUM_CH), .NUM_OUT(NUM_OUT)) bus ();

  ok_snapshot_pager #(.NUM_CH(NUM_CH), .NUM_OUT(NUM_OUT)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [79:0] words;
    logic [15:0] status;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic ack_prev = 1'b0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] pack5(input logic [15:0] w0, w1, w2, w3, w4);
    return {w4, w3, w2, w1, w0};
  endfunction

  task automatic set_ch(input logic [15:0] base);
    for (int k = 0; k < NUM_CH; k++) bus.ch_data[16*k +: 16] = base + 16'(k);
  endtask

  // Monitor: one scoreboard entry per rising ack.
  always @(negedge clk) begin
    if (reset) begin
      ack_prev = 1'b0;
    end else begin
      if (bus.ep_status[0] && !ack_prev) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_ack", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_ep_out", bus.ep_out, e.words);
          check("sb_ep_status", bus.ep_status, e.status);
        end
      end
      ack_prev = bus.ep_status[0];
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
  task automatic run_txn(input logic [15:0] ctrl, input logic [79:0] words,
                         input logic [15:0] status, input int lat,
                         input bit scramble, input bit hold,
                         input bit use_alt, input logic [15:0] alt_ctrl);
    exp_t       e;
    int         n;
    logic       got;
    logic [7:0] exp_led;
    e.words  = words;
    e.status = status;
    sb_q.push_back(e);
    exp_led     = ~status[7:0];
    bus.ep_ctrl = ctrl;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 2) check("busy_in_load", bus.ep_status[1], 1);
      if (scramble && n >= 2)
        for (int w = 0; w < 8; w++) bus.ch_data[32*w +: 32] = $urandom();
      if (use_alt && n == 3) bus.ep_ctrl = alt_ctrl;
      got = bus.ep_status[0];
    end
    check("ack_latency", n, lat);
    check("led_at_ack", bus.led, exp_led);
    if (hold) begin
      repeat (10) @(posedge clk);
      #1;
      check("hold_status", bus.ep_status, status);
    end
    @(negedge clk);
    bus.ep_ctrl = '0;
    @(posedge clk);
    #1;
    check("ack_drop_status", bus.ep_status, status & 16'hFFFE);
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [79:0] words;
    logic [3:0]  p;
    int          idx;
    logic [15:0] wv [5];

    bus.ep_ctrl = '0;
    bus.ch_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ep_out", bus.ep_out, 0);
    check("reset_status", bus.ep_status, 16'h0000);
    check("reset_led", bus.led, 8'hFF);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Mode 0, page 1.
    set_ch(16'hA000);
    run_txn(16'h0101, pack5(16'hA005, 16'hA006, 16'hA007, 16'hA008, 16'hA009),
            16'h0111, 7, 0, 0, 0, 16'h0);

    // Partial last page with ch_data churning after the capture edge.
    run_txn(16'h0301, pack5(16'hA00F, 16'h0, 16'h0, 16'h0, 16'h0),
            16'h0231, 7, 1, 0, 0, 16'h0);

    // Mode 1 re-page of the page-3 snapshot; live data must not leak in.
    set_ch(16'hB000);
    run_txn(16'h0003, pack5(16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004),
            16'h0201, 6, 0, 0, 0, 16'h0);

    // Out-of-range page.
    run_txn(16'h0403, pack5(16'h0, 16'h0, 16'h0, 16'h0, 16'h0),
            16'h0245, 6, 0, 0, 0, 16'h0);

    // req held through ACK: no second transaction.
    run_txn(16'h0201, pack5(16'hB00A, 16'hB00B, 16'hB00C, 16'hB00D, 16'hB00E),
            16'h0321, 7, 0, 1, 0, 16'h0);

    // Page field rewritten mid-LOAD must be ignored.
    run_txn(16'h0101, pack5(16'hB005, 16'hB006, 16'hB007, 16'hB008, 16'hB009),
            16'h0411, 7, 0, 0, 1, 16'h0F01);

    // 256 back-to-back captures; seq runs 5..255, 0..4.
    for (int i = 0; i < 256; i++) begin
      p = 4'(i % 4);
      for (int k = 0; k < NUM_CH; k++) bus.ch_data[16*k +: 16] = {8'(i), 8'(k)};
      for (int j = 0; j < 5; j++) begin
        idx   = int'(p) * 5 + j;
        wv[j] = (idx < NUM_CH) ? {8'(i), 8'(idx)} : 16'h0;
      end
      words = pack5(wv[0], wv[1], wv[2], wv[3], wv[4]);
      run_txn({4'h0, p, 8'h01}, words, {8'(5 + i), p, 4'b0001}, 7, 0, 0, 0, 16'h0);
    end

    // Reset mid-LOAD with req held; a fresh transaction follows.
    set_ch(16'hC000);
    bus.ep_ctrl = 16'h0101;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midload_reset_ep_out", bus.ep_out, 0);
    check("midload_reset_status", bus.ep_status, 16'h0000);
    check("midload_reset_led", bus.led, 8'hFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_txn(16'h0101, pack5(16'hC005, 16'hC006, 16'hC007, 16'hC008, 16'hC009),
            16'h0111, 7, 0, 0, 0, 16'h0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
